// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer: multi-cycle wide adder controller.
// Adds two W = N*K bit operands by time-multiplexing one N-bit adder_n
// slice over K cycles, least-significant slice first, with the ripple
// carry held in a register between slices. Valid/ready handshakes on
// both the operand side and the result side.
//
// Build option: define WIDE_ADD_SUB_EN to add the 'sub' port, which turns
// the operation into a - b (b inverted, carry-in forced to 1).

// Single N-bit ripple slice; the only adder in the design.
module adder_n #(
    parameter int N = 8
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         c_i,
    output logic [N-1:0] s_o,
    output logic         c_o
);

    assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{N{1'b0}}, c_i};

endmodule

module wide_add_sequencer #(
    parameter int N = 8,
    parameter int K = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N*K-1:0]   a,
    input  logic [N*K-1:0]   b,
    input  logic             c_in,
`ifdef WIDE_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N*K-1:0]   sum,
    output logic             c_out,
    output logic             overflow
);

    localparam int W     = N * K;
    localparam int CNT_W = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e           state_q;
    logic [W-1:0]     a_sh_q;
    logic [W-1:0]     b_sh_q;
    logic [W-1:0]     result_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;
    logic             a_msb_q;
    logic             b_msb_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             c_out_q;
    logic             overflow_q;

    logic [W-1:0]     a_sh_d;
    logic [W-1:0]     b_sh_d;
    logic [W-1:0]     result_d;
    logic [W-1:0]     b_eff;
    logic             c_init;
    logic [N-1:0]     slice_sum;
    logic             slice_co;
    logic             last_slice;

    // Effective B operand and initial carry; subtraction is a + ~b + 1.
`ifdef WIDE_ADD_SUB_EN
    assign b_eff  = sub ? ~b : b;
    assign c_init = sub ? 1'b1 : c_in;
`else
    assign b_eff  = b;
    assign c_init = c_in;
`endif

    adder_n #(.N(N)) u_slice (
        .a_i (a_sh_q[N-1:0]),
        .b_i (b_sh_q[N-1:0]),
        .c_i (carry_q),
        .s_o (slice_sum),
        .c_o (slice_co)
    );

    assign a_sh_d     = a_sh_q >> N;
    assign b_sh_d     = b_sh_q >> N;
    assign last_slice = (cnt_q == CNT_W'(K - 1));

    // Each slice result enters at the top of the result register, so after
    // K slices the least-significant slice has reached bit 0.
    generate
        if (K == 1) begin : g_single
            assign result_d = slice_sum;
        end else begin : g_multi
            assign result_d = {slice_sum, result_q[W-1:N]};
        end
    endgenerate

    // Control FSM and datapath registers, all outputs registered.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q     <= IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            a_msb_q     <= 1'b0;
            b_msb_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            c_out_q     <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_sh_q     <= a;
                        b_sh_q     <= b_eff;
                        carry_q    <= c_init;
                        cnt_q      <= '0;
                        a_msb_q    <= a[W-1];
                        b_msb_q    <= b_eff[W-1];
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    result_q <= result_d;
                    carry_q  <= slice_co;
                    a_sh_q   <= a_sh_d;
                    b_sh_q   <= b_sh_d;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (last_slice) begin
                        out_valid_q <= 1'b1;
                        c_out_q     <= slice_co;
                        overflow_q  <= (a_msb_q == b_msb_q) &&
                                       (slice_sum[N-1] != a_msb_q);
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = result_q;
    assign c_out     = c_out_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Self-checking bench for wide_add_sequencer (N=8, K=4) using directed
// vectors with hand-computed expected results. Subtract vectors run only
// when WIDE_ADD_SUB_EN is defined.
module tb_wide_add_sequencer;

    localparam int N = 8;
    localparam int K = 4;
    localparam int W = N * K;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         c_out;
    logic         overflow;

    int checks   = 0;
    int failures = 0;

    wide_add_sequencer #(.N(N), .K(K)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
`ifdef WIDE_ADD_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Watchdog: the bench must never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for out_valid; returns cycles elapsed.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
    endtask

    // One full transaction with out_ready held high.
    task automatic run_add(input string tag, input logic [W-1:0] aa, input logic [W-1:0] bb,
                           input logic ci, input logic sb, input logic [W-1:0] es,
                           input logic ec, input logic eo);
        int lat;
        check({tag, ".in_ready"}, in_ready, 1'b1);
        a = aa; b = bb; c_in = ci; sub = sb; out_ready = 1'b1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_valid(lat);
        check({tag, ".latency"}, lat, K);
        check({tag, ".sum"}, sum, es);
        check({tag, ".c_out"}, c_out, ec);
        check({tag, ".overflow"}, overflow, eo);
        step();
        check({tag, ".idle_valid"}, out_valid, 1'b0);
    endtask

    logic [W-1:0] bb_a [3];
    logic [W-1:0] bb_b [3];
    logic [W-1:0] bb_s [3];

    initial begin
        int lat;
        int idx;
        int got;
        int cyc;
        int last_cyc;

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0; out_ready = 1'b0;
        step();
        step();
        check("reset.in_ready", in_ready, 1'b1);
        check("reset.out_valid", out_valid, 1'b0);
        check("reset.sum", sum, 32'h0);
        check("reset.c_out", c_out, 1'b0);
        check("reset.overflow", overflow, 1'b0);
        rst = 1'b0;
        step();

        // Basic arithmetic and boundaries
        run_add("ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        run_add("pos_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        run_add("cin", 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0);
        run_add("neg_ovf", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1);

        // Backpressure and busy behaviour
        out_ready = 1'b0;
        a = 32'h0000_0010; b = 32'h0000_0020; c_in = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        check("busy.in_ready_run", in_ready, 1'b0);
        a = 32'h0000_0100; b = 32'h0000_0200; in_valid = 1'b1;
        lat = 1;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        check("busy.latency", lat, K);
        for (int i = 0; i < 5; i++) begin
            check("bp.sum", sum, 32'h0000_0030);
            check("bp.out_valid", out_valid, 1'b1);
            check("bp.in_ready", in_ready, 1'b0);
            step();
        end
        out_ready = 1'b1;
        step();
        check("bp.release_in_ready", in_ready, 1'b1);
        check("bp.release_out_valid", out_valid, 1'b0);
        step();
        in_valid = 1'b0;
        check("bp.second_accepted", in_ready, 1'b0);
        wait_valid(lat);
        check("bp.second_latency", lat, K);
        check("bp.second_sum", sum, 32'h0000_0300);
        step();

        // Reset in the middle of a run
        a = 32'h0000_AAAA; b = 32'h0000_5555; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort.in_ready", in_ready, 1'b1);
        check("abort.out_valid", out_valid, 1'b0);
        check("abort.sum", sum, 32'h0);
        check("abort.c_out", c_out, 1'b0);
        run_add("after_abort", 32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, 32'h0000_0007, 1'b0, 1'b0);

`ifdef WIDE_ADD_SUB_EN
        run_add("sub_neg", 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_add("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        sub = 1'b0;
`endif

        // Back-to-back with out_ready tied high
        bb_a[0] = 32'h0000_0001; bb_b[0] = 32'h0000_0002; bb_s[0] = 32'h0000_0003;
        bb_a[1] = 32'h0000_FFFF; bb_b[1] = 32'h0000_0001; bb_s[1] = 32'h0001_0000;
        bb_a[2] = 32'h0100_0000; bb_b[2] = 32'h00FF_FFFF; bb_s[2] = 32'h01FF_FFFF;
        out_ready = 1'b1; c_in = 1'b0;
        idx = 0; got = 0; cyc = 0; last_cyc = 0;
        a = bb_a[0]; b = bb_b[0]; in_valid = 1'b1;
        while (got < 3 && cyc < 60) begin
            logic accepting;
            accepting = in_ready && in_valid;
            step();
            cyc++;
            if (accepting) begin
                idx++;
                if (idx < 3) begin
                    a = bb_a[idx]; b = bb_b[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid) begin
                check("b2b.sum", sum, bb_s[got]);
                if (got > 0) check("b2b.interval", cyc - last_cyc, K + 2);
                last_cyc = cyc;
                got++;
            end
        end
        in_valid = 1'b0;
        check("b2b.count", got, 3);
        check("b2b.accepted", idx, 3);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wide_add_sequencer.md
Name: wide_add_sequencer

Overview:
- Multi-cycle wide adder controller: time-multiplexes one N-bit adder_n slice over K cycles to add two N*K-bit operands.
- Ripple carry is held in a register between slices, least-significant slice first.
- Valid/ready handshake on input and output, so it can sit between pipeline stages in the datapath in place of a wide combinational adder.

Parameters:
- N, 8, slice width in bits; width of the single adder_n instance.
- K, 4, number of slices, K >= 1; operand width W = N*K (local constant, not overridable).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  operand set offered.
- in_ready  output  1  block can accept operands.
- a  input  W  operand A, sampled on input handshake.
- b  input  W  operand B, sampled on input handshake.
- c_in  input  1  carry into bit 0, sampled on input handshake.
- sub  input  1  subtract request; only present when WIDE_ADD_SUB_EN is defined.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- sum  output  W  result, stable while out_valid=1.
- c_out  output  1  carry out of bit W-1.
- overflow  output  1  two's-complement signed overflow of the W-bit result.

Behaviour:
- Reset state: IDLE. Outputs on reset: in_ready=1, out_valid=0, sum=0, c_out=0, overflow=0. Slice counter, carry register and operand shift registers are cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1.
  - On in_valid&&in_ready: latch a, b, c_in into the shift registers and the carry register; counter=0; go to RUN.
- RUN: in_ready=0, out_valid=0. Each cycle:
  - The adder input is the low N bits of A_sh and B_sh, with carry = carry register.
  - The slice sum is shifted into the top of the result register (result >> N, slice at [W-1:W-N]).
  - carry register <= adder c_out; A_sh and B_sh shift right by N; counter++.
  - After the K-th RUN cycle (counter==K-1 at the edge), go to DONE.
- DONE: out_valid=1; sum, c_out and overflow are held constant.
  - On out_ready: go to IDLE; out_valid falls and in_ready rises the next cycle.
  - in_ready=0 in DONE; no overlap of input and output handshakes.
- Latency: out_valid rises exactly K cycles after the accepting edge. Throughput: one result per K+2 cycles with out_ready held high.
- c_out: carry register value after the last slice.
- overflow: (a[W-1] == b_eff[W-1]) && (sum[W-1] != a[W-1]).
  - b_eff is b, or ~b in subtract mode; the MSBs of a and b_eff are captured at accept.
- K=1: single RUN cycle; behaviour is otherwise identical.
- in_valid while busy (RUN or DONE): ignored, no sampling. The source must hold its data until in_ready.
- a, b, c_in changing during RUN: no effect, because operands are already latched.
- out_ready asserted in IDLE or RUN: ignored.
- rst mid-RUN or in DONE: abort. State becomes IDLE and outputs return to reset values on the next edge. The in-flight result is discarded.
- Arithmetic is modulo 2^W. All carries are propagated through the register; no slice carry is dropped.

Optional Feature:
- Macro: WIDE_ADD_SUB_EN.
- Defined:
  - The sub port exists and is sampled on the input handshake.
  - sub=1 latches ~b as B_sh and forces the initial carry to 1 (c_in is ignored), giving a-b.
  - c_out=1 means no borrow. overflow uses b_eff=~b.
- Undefined:
  - No sub port; addition only. overflow uses b_eff=b.

Test Plan:
- N=8,K=4 carry ripple: a=0xFFFFFFFF, b=0x00000001, c_in=0, out_ready=1 -> out_valid rises 4 cycles after accept; sum=0x00000000, c_out=1, overflow=0.
- Signed overflow: a=0x7FFFFFFF, b=0x00000001, c_in=0 -> sum=0x80000000, c_out=0, overflow=1. Also a=0x12345678, b=0x11111111, c_in=1 -> sum=0x2345678A, c_out=0.
- Backpressure and busy: out_ready=0 for 5 cycles after out_valid -> sum held and in_ready=0 throughout. A second in_valid during RUN is not accepted. After out_ready=1, in_ready=1 on the next cycle and the second operand set is accepted.
- Reset mid-operation: assert rst for 1 cycle on the 2nd RUN cycle -> next cycle in_ready=1, out_valid=0, sum=0. A fresh add 0x00000003+0x00000004 then gives 0x00000007.
- WIDE_ADD_SUB_EN defined, sub=1:
  - a=5, b=7 -> sum=0xFFFFFFFE, c_out=0, overflow=0.
  - a=0x80000000, b=1 -> sum=0x7FFFFFFF, c_out=1, overflow=1.
- Back-to-back with out_ready tied high, 3 transactions -> results appear every K+2=6 cycles, each correct; no transaction is lost or duplicated.
